// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle fetch/decode/execute/memory/write-back controller.
// CTRL is registered from the next-state decode so it always matches STATE.
module ctrl_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSTRUCTION,
  input  logic        ZERO,
  input  logic        MEM_READY,
  output logic [31:0] CTRL,
  output logic [2:0]  STATE,
  output logic [31:0] INSTR_COUNT,
  output logic        ILLEGAL
);
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXE    = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        zero_q, zero_d;
  logic [31:0] ctrl_d;

  logic [5:0]  opcode, funct;
  logic        legal, mem_rd, mem_wr, is_push, reg_wr, sp_ld;
  logic        pc_sel_1, pc_sel_3, is_beq, is_bne, taken;
  logic [4:0]  alu_op;
  logic [4:0]  opnd_sel;  // {op2_sel_4, op2_sel_3, op2_sel_2, op2_sel_1, op1_sel_1}
  logic [2:0]  wa_sel;    // {wa_sel_3, wa_sel_2, wa_sel_1}
  logic [2:0]  wd_sel;    // {wd_sel_3, wd_sel_2, wd_sel_1}
  logic        ir_unused;

  // Decode works on the IR value that will be current next cycle, so the
  // registered control word lines up with the state it belongs to.
  assign ir_d      = (state_q == S_FETCH && MEM_READY) ? INSTRUCTION : ir_q;
  assign zero_d    = (state_q == S_EXE) ? ZERO : zero_q;
  assign opcode    = ir_d[31:26];
  assign funct     = ir_d[5:0];
  assign ir_unused = ^ir_d[25:6];
  assign taken     = (is_beq & zero_d) | (is_bne & ~zero_d);

  always_comb begin
    legal    = 1'b1;
    alu_op   = '0;
    opnd_sel = '0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    is_push  = 1'b0;
    reg_wr   = 1'b0;
    wa_sel   = '0;
    wd_sel   = '0;
    sp_ld    = 1'b0;
    pc_sel_1 = 1'b1;
    pc_sel_3 = 1'b1;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    if (opcode == 6'h00) begin
      opnd_sel = 5'b10000;
      reg_wr   = 1'b1;
      wa_sel   = 3'b100;
      wd_sel   = 3'b100;
      case (funct)
        6'h20: alu_op = 5'd1;
        6'h22: alu_op = 5'd2;
        6'h2C: alu_op = 5'd3;
        6'h24: alu_op = 5'd6;
        6'h25: alu_op = 5'd7;
        6'h27: alu_op = 5'd8;
        6'h2A: alu_op = 5'd9;
        6'h01: begin alu_op = 5'd5; opnd_sel = 5'b01010; end
        6'h02: begin alu_op = 5'd4; opnd_sel = 5'b01010; end
        6'h08: begin reg_wr = 1'b0; wa_sel = '0; wd_sel = '0; pc_sel_1 = 1'b0; end
        default: legal = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'h08: begin alu_op = 5'd1; opnd_sel = 5'b00100; reg_wr = 1'b1; wa_sel = 3'b101; wd_sel = 3'b100; end
        6'h1D: begin alu_op = 5'd3; opnd_sel = 5'b00100; reg_wr = 1'b1; wa_sel = 3'b101; wd_sel = 3'b100; end
        6'h0C: begin alu_op = 5'd6; reg_wr = 1'b1; wa_sel = 3'b101; wd_sel = 3'b100; end
        6'h0D: begin alu_op = 5'd7; reg_wr = 1'b1; wa_sel = 3'b101; wd_sel = 3'b100; end
        6'h0F: begin reg_wr = 1'b1; wa_sel = 3'b101; wd_sel = 3'b110; end
        6'h0A: begin alu_op = 5'd9; opnd_sel = 5'b00100; reg_wr = 1'b1; wa_sel = 3'b101; wd_sel = 3'b100; end
        6'h04: begin alu_op = 5'd2; opnd_sel = 5'b10000; is_beq = 1'b1; end
        6'h05: begin alu_op = 5'd2; opnd_sel = 5'b10000; is_bne = 1'b1; end
        6'h23: begin
          alu_op = 5'd1; opnd_sel = 5'b00100; mem_rd = 1'b1;
          reg_wr = 1'b1; wa_sel = 3'b101; wd_sel = 3'b101;
        end
        6'h2B: begin alu_op = 5'd1; opnd_sel = 5'b00100; mem_wr = 1'b1; end
        6'h02: pc_sel_3 = 1'b0;
        6'h03: begin pc_sel_3 = 1'b0; reg_wr = 1'b1; wa_sel = 3'b010; wd_sel = 3'b000; end
        6'h1B: begin alu_op = 5'd2; opnd_sel = 5'b01001; mem_wr = 1'b1; is_push = 1'b1; sp_ld = 1'b1; end
        6'h1C: begin
          alu_op = 5'd1; opnd_sel = 5'b01001; mem_rd = 1'b1; sp_ld = 1'b1;
          reg_wr = 1'b1; wa_sel = 3'b000; wd_sel = 3'b101;
        end
        default: legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (MEM_READY) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXE : S_FETCH;
      S_EXE:    state_d = (mem_rd | mem_wr) ? S_MEM : S_WB;
      S_MEM:    if (MEM_READY) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_RESET;
    endcase
  end

  // ALU/operand selects stay asserted through MEM and WB so the address and
  // write-back data from the combinational ALU remain stable.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d[31] = 1'b1;
        ctrl_d[30] = 1'b1;
        ctrl_d[4]  = 1'b1;
      end
      S_DECODE: begin
        ctrl_d[7] = 1'b1;
        ctrl_d[6] = ~is_push;
      end
      S_EXE: ctrl_d[25:16] = {alu_op, opnd_sel};
      S_MEM: begin
        ctrl_d[25:16] = {alu_op, opnd_sel};
        ctrl_d[27]    = mem_rd;
        ctrl_d[4]     = mem_rd;
        ctrl_d[28]    = mem_wr;
        ctrl_d[5]     = mem_wr;
        ctrl_d[26]    = is_push;
        ctrl_d[29]    = is_push;
      end
      S_WB: begin
        ctrl_d[25:16] = {alu_op, opnd_sel};
        ctrl_d[15]    = sp_ld;
        ctrl_d[14:12] = wd_sel;
        ctrl_d[11:9]  = wa_sel;
        ctrl_d[8]     = reg_wr;
        ctrl_d[3]     = pc_sel_3;
        ctrl_d[2]     = taken;
        ctrl_d[1]     = pc_sel_1;
        ctrl_d[0]     = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_RESET;
      ir_q        <= '0;
      zero_q      <= 1'b0;
      CTRL        <= '0;
      INSTR_COUNT <= '0;
      ILLEGAL     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      zero_q  <= zero_d;
      CTRL    <= ctrl_d;
      ILLEGAL <= (state_d == S_DECODE) && !legal;
      if (state_d == S_WB) INSTR_COUNT <= INSTR_COUNT + 32'd1;
    end
  end

  assign STATE = state_q;

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle control unit for the 32-bit cs147sec05 processor. It drives the 32-bit `CTRL` bus of the data path through five phases per instruction: fetch, decode, execute, memory, write-back. It decodes the fetched instruction and samples the ALU `ZERO` flag for branches. It stalls on a memory-ready handshake, counts retired instructions and flags illegal opcodes.

## Interface
- No parameters. `CTRL` width is fixed at 32; state encoding is fixed at 3 bits.
- `CLK  input  1  ` system clock; everything updates on the rising edge.
- `RST  input  1  ` reset, synchronous, active-high.
- `INSTRUCTION  input  32  ` instruction word from the data path; valid while `MEM_READY`=1 in FETCH.
- `ZERO  input  1  ` ALU zero flag from the data path.
- `MEM_READY  input  1  ` memory completion; qualifies FETCH and MEM.
- `CTRL  output  32  ` registered control word.
  - Bit map: 0 pc_load, 1 pc_sel_1, 2 pc_sel_2, 3 pc_sel_3, 4 mem_r, 5 mem_w, 6 r1_sel_1, 7 reg_r, 8 reg_w, 9–11 wa_sel_1..3, 12–14 wd_sel_1..3, 15 sp_load, 16 op1_sel_1, 17–20 op2_sel_1..4, 25:21 alu_oprn, 26 ma_sel_1, 27 dmem_r, 28 dmem_w, 29 md_sel_1, 30 ir_load, 31 ma_sel_2.
- `STATE  output  3  ` current state, for debug.
- `INSTR_COUNT  output  32  ` number of retired instructions.
- `ILLEGAL  output  1  ` one-cycle pulse when an unknown opcode or funct is decoded.

## Operation
- **States:** RESET=0, FETCH=1, DECODE=2, EXE=3, MEM=4, WB=5.
- **Transitions:**
  - RESET→FETCH unconditionally.
  - FETCH→DECODE when `MEM_READY`=1; otherwise stay in FETCH.
  - DECODE→EXE, or DECODE→FETCH if the instruction is illegal.
  - EXE→MEM for lw, sw, push, pop; EXE→WB for everything else.
  - MEM→WB when `MEM_READY`=1; otherwise stay in MEM.
  - WB→FETCH.
- **FETCH:** ma_sel_2=1, mem_r=1, ir_load=1. On the exit edge, `INSTRUCTION` is latched into an internal IR. All later decoding uses the IR, never the live input.
- **DECODE:**
  - reg_r=1.
  - r1_sel_1=1, except push, which uses 0 so that R[0] is read.
  - Unknown opcode or R-type funct → `ILLEGAL` pulse, no retire, PC unchanged.
- **Opcodes:**
  - R-type is opcode 0x00 with funct add 20, sub 22, mul 2C, and 24, or 25, nor 27, slt 2A, sll 01, srl 02, jr 08.
  - I-type: addi 08, muli 1D, andi 0C, ori 0D, lui 0F, slti 0A, beq 04, bne 05, lw 23, sw 2B.
  - J-type: jmp 02, jal 03, push 1B, pop 1C.
- **alu_oprn codes:** add=1, sub=2, mul=3, srl=4, sll=5, and=6, or=7, nor=8, slt=9.
- **EXE, operand selects:**
  - R-type: op2_sel_4=1.
  - sll/srl: op2_sel_4=0, op2_sel_3=1, op2_sel_1=1 (shamt).
  - addi, muli, slti, lw, sw: op2_sel_2=1 (sign-extended immediate).
  - andi, ori: op2_sel_2=0 (zero-extended immediate).
  - beq/bne: sub with op2_sel_4=1; `ZERO` is registered at the end of EXE.
  - push: op1_sel_1=1, operand 2 = 1, sub.
  - pop: op1_sel_1=1, operand 2 = 1, add.
- **MEM:**
  - lw: dmem_r=1, mem_r=1, ma_sel_1=0.
  - sw: dmem_w=1, mem_w=1, md_sel_1=0.
  - push: write to M[sp] with ma_sel_1=1, md_sel_1=1.
  - pop: read from M[sp+1] with ma_sel_1=0.
  - ma_sel_2=0 throughout MEM.
- **WB, register write (reg_w=1):**
  - ALU results: wd_sel_3=1.
  - lw and pop: wd_sel_1=1.
  - lui: wd_sel_2=1.
  - Write address: rt (wa_sel_1=1, wa_sel_3=1) for I-type; rd for R-type; R0 for pop (wa_sel_3=0, wa_sel_2=0).
  - jal: selects register 31 (wa_sel_3=0, wa_sel_2=1) and writes PC+1 (wd_sel_3=0).
- **WB, stack pointer:** sp_load=1 for push and pop.
- **WB, PC update (pc_load=1 for every legal instruction):**
  - Default: PC+1 (pc_sel_1=1, pc_sel_2=0, pc_sel_3=1).
  - Taken beq/bne: pc_sel_2=1.
  - jr: pc_sel_1=0.
  - jmp/jal: pc_sel_3=0.
- **Instruction count:** `INSTR_COUNT` increments by 1 in WB and wraps modulo 2^32.

## Timing
- **Reset:** with `RST` high at a rising edge, the next state is RESET and the outputs become `CTRL`=0, `STATE`=0, `INSTR_COUNT`=0, `ILLEGAL`=0, IR=0.
  - `RST` takes priority over every transition, including mid-MEM and mid-stall.
  - No pending write or pc_load survives a reset.
- **CTRL timing:** `CTRL` is registered and reflects the current state. Cross-state glitches are forbidden.
- **Latency:**
  - 4 cycles for non-memory instructions.
  - 5 cycles for memory instructions.
  - Each cycle with `MEM_READY`=0 in FETCH or MEM adds one cycle.
- **Write strobes:** reg_w, sp_load and pc_load are high for exactly one cycle per instruction, in WB only.
- **Stalls:** while stalled, `CTRL` holds unchanged.
- **Branch decision:** uses the `ZERO` value registered in EXE, not a later value.

## Test plan
- **Reset:** `RST`=1 for 2 cycles, then 0 → `CTRL`=0 and `INSTR_COUNT`=0 during reset; `STATE` goes 0→1, and FETCH shows bits 4, 30 and 31 set.
- **R-type add:** instruction 0x00221820 (add r3,r1,r2) with `MEM_READY`=1 → states 1,2,3,5; alu_oprn=1 and op2_sel_4=1 in EXE; in WB, reg_w=1, rd selected, pc_load=1; `INSTR_COUNT`=1.
- **lw with stalls:** lw (0x8C220004) with `MEM_READY` low for 3 cycles in MEM → `STATE` holds 4 for 4 cycles; dmem_r=1 throughout; WB has wd_sel_1=1 and wa_sel_1=1.
- **Branches:** beq with `ZERO`=1 in EXE → pc_sel_2=1 in WB. Same instruction with `ZERO`=0 → pc_sel_2=0.
- **Stack:** push (0x6C000000) then pop (0x70000000) → push has ALU sub, ma_sel_1=1, md_sel_1=1 and sp_load in WB; pop has add, writes R0 via wd_sel_1, and sp_load.
- **Illegal and reset-in-flight:** opcode 0x3F → `ILLEGAL` pulses one cycle, return to FETCH, `INSTR_COUNT` unchanged. `RST` asserted while in MEM → next state 0, `CTRL`=0.
